multicycle_ctrl: RTL

//  Multi-cycle sequencer for the ARM datapath. Replaces the single-cycle control path.

---
 rtl/mc_pkg.sv | 66 ++++++
 rtl/mc_if.sv | 32 +++
 rtl/mc_out_decode.sv | 66 ++++++
 rtl/multicycle_ctrl.sv | 100 ++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle ARM control sequencer: state codes,
// datapath select values, ALU command constants and the select/enable bundles.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } op_e;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_READ   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
  } sel_t;

  // Ungated enables; the top level qualifies them with CondEx and reset.
  typedef struct packed {
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       pcs;
    logic [1:0] flag_w;
  } raw_en_t;

  // Arithmetic commands also update the carry/overflow flags.
  function automatic logic sets_cv(input logic [3:0] cmd);
    return (cmd == CMD_SUB) || (cmd == CMD_ADD) || (cmd == CMD_CMP);
  endfunction

  function automatic logic no_writeback(input logic [3:0] cmd);
    return (cmd == CMD_TST) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: instruction fields and status in, selects and enables out.
interface mc_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;
  logic       MemReady;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ALUOp;
  logic       RegWrite;
  logic [1:0] FlagW;
  logic       Illegal;

  modport master (
    input  Op, Funct, Rd, CondEx, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, RegWrite, FlagW, Illegal
  );

  modport slave (
    output Op, Funct, Rd, CondEx, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, RegWrite, FlagW, Illegal
  );
endinterface

// File: rtl/mc_out_decode.sv
// Moore output decode: current state plus instruction fields -> datapath selects
// and raw (not yet condition-gated) write enables.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_e     state,
  input  logic [4:0] funct,
  input  logic [3:0] rd,
  output sel_t       sel,
  output raw_en_t    en
);

  logic [3:0] cmd;
  logic       s_bit;
  logic       alu_reg_w;
  logic       rd_is_pc;

  assign cmd       = funct[4:1];
  assign s_bit     = funct[0];
  assign alu_reg_w = !no_writeback(cmd);
  assign rd_is_pc  = (rd == REG_PC);

  always_comb begin
    sel = '0;
    en  = '0;
    case (state)
      S_FETCH, S_DECODE: begin
        sel.alu_src_a  = 1'b1;
        sel.alu_src_b  = SRCB_FOUR;
        sel.result_src = RES_ALURES;
      end
      S_MEMADR: sel.alu_src_b = SRCB_IMM;
      S_MEMRD:  sel.adr_src   = 1'b1;
      S_MEMWB: begin
        sel.result_src = RES_READ;
        en.reg_w       = 1'b1;
        en.pcs         = rd_is_pc;
      end
      S_MEMWR: begin
        sel.adr_src = 1'b1;
        en.mem_w    = 1'b1;
      end
      S_EXECR: begin
        sel.alu_src_b = SRCB_RD2;
        sel.alu_op    = 1'b1;
      end
      S_EXECI: begin
        sel.alu_src_b = SRCB_IMM;
        sel.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        sel.result_src = RES_ALUOUT;
        en.reg_w       = alu_reg_w;
        en.pcs         = alu_reg_w & rd_is_pc;
        en.flag_w      = {s_bit, s_bit & sets_cv(cmd)};
      end
      S_BRANCH: begin
        sel.alu_src_b  = SRCB_IMM;
        sel.result_src = RES_ALURES;
        en.branch      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle ARM sequencer: state register, next-state logic, CondEx/reset
// gating of the write enables and the retired-instruction counter.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  mc_if.master             bus,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] RetireCnt
);

  state_e  state_q, state_d;
  logic    next_pc;
  logic    ir_write;
  logic    illegal;
  logic    retire;
  sel_t    sel;
  raw_en_t en;

  always_ff @(posedge CLK) begin
    if (!RESETn) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    next_pc  = 1'b0;
    ir_write = 1'b0;
    illegal  = 1'b0;
    retire   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.MemReady) begin
          ir_write = 1'b1;
          next_pc  = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_e'(bus.Op))
          OP_MEM: state_d = S_MEMADR;
          OP_DP:  state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:  state_d = S_BRANCH;
          OP_UND: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.MemReady) state_d = S_MEMWB;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (bus.MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  mc_out_decode u_dec (
    .state (state_q),
    .funct (bus.Funct[4:0]),
    .rd    (bus.Rd),
    .sel   (sel),
    .en    (en)
  );

  assign bus.AdrSrc    = sel.adr_src;
  assign bus.ResultSrc = sel.result_src;
  assign bus.ALUSrcA   = sel.alu_src_a;
  assign bus.ALUSrcB   = sel.alu_src_b;
  assign bus.ALUOp     = sel.alu_op;

  // Reset dominates every enable so an interrupted store never commits.
  assign bus.PCWrite  = RESETn & (next_pc | ((en.branch | en.pcs) & bus.CondEx));
  assign bus.IRWrite  = RESETn & ir_write;
  assign bus.RegWrite = RESETn & en.reg_w & bus.CondEx;
  assign bus.MemWrite = RESETn & en.mem_w & bus.CondEx;
  assign bus.FlagW    = en.flag_w & {2{RESETn & bus.CondEx}};
  assign bus.Illegal  = RESETn & illegal;

  always_ff @(posedge CLK) begin
    if (!RESETn)     RetireCnt <= '0;
    else if (retire) RetireCnt <= RetireCnt + CNT_W'(1);
  end

  assign State = state_q;

endmodule
